// File: rtl/i2c_config_seq.sv
// Table-driven I2C configuration sequencer: walks a LUT of register writes,
// optional read-back verification, delay entries and per-entry retries.
module i2c_config_seq #(
    parameter int LUT_AW    = 10,
    parameter int MAX_RETRY = 3,
    parameter int DELAY_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              verify_en,
    output logic [LUT_AW-1:0] lut_index,
    input  logic [7:0]        lut_dev_addr,
    input  logic [15:0]       lut_reg_addr,
    input  logic [7:0]        lut_reg_data,
    output logic              i2c_write_req,
    output logic              i2c_read_req,
    input  logic              i2c_write_req_ack,
    input  logic              i2c_read_req_ack,
    input  logic              i2c_error,
    input  logic [7:0]        i2c_read_data,
    output logic [7:0]        i2c_slave_dev_addr,
    output logic [15:0]       i2c_slave_reg_addr,
    output logic [7:0]        i2c_write_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {IDLE, CHECK, WR, RD, DLY, DONE} state_t;

    localparam logic [3:0]        MAX_RETRY_C = 4'(MAX_RETRY);
    localparam logic [LUT_AW-1:0] LAST_IDX    = '1;

    state_t              state_q, state_d;
    logic [LUT_AW-1:0]   lut_index_q, lut_index_d;
    logic [3:0]          retry_q, retry_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                error_q, error_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic [7:0]          dev_q, dev_d;
    logic [15:0]         reg_q, reg_d;
    logic [7:0]          data_q, data_d;

    logic [23:0]         delay_src;
    logic                do_fail;
    logic                do_adv;

    assign delay_src = {lut_reg_addr, lut_reg_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lut_index_q <= '0;
            retry_q     <= '0;
            delay_q     <= '0;
            err_cnt_q   <= '0;
            error_q     <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            lut_index_q <= lut_index_d;
            retry_q     <= retry_d;
            delay_q     <= delay_d;
            err_cnt_q   <= err_cnt_d;
            error_q     <= error_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lut_index_d = lut_index_q;
        retry_d     = retry_q;
        delay_d     = delay_q;
        err_cnt_d   = err_cnt_q;
        error_d     = error_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        data_d      = data_q;
        do_fail     = 1'b0;
        do_adv      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = CHECK;
                    lut_index_d = '0;
                    retry_d     = '0;
                    error_d     = 1'b0;
                    err_cnt_d   = '0;
                end
            end
            CHECK: begin
                if (lut_dev_addr == 8'hFF) begin
                    state_d = DONE;
                end else if (lut_dev_addr == 8'hFE) begin
                    delay_d = delay_src[DELAY_W-1:0];
                    state_d = DLY;
                end else begin
                    dev_d    = lut_dev_addr;
                    reg_d    = lut_reg_addr;
                    data_d   = lut_reg_data;
                    wr_req_d = 1'b1;
                    state_d  = WR;
                end
            end
            WR: begin
                if (i2c_write_req_ack) begin
                    wr_req_d = 1'b0;
                    if (i2c_error) begin
                        do_fail = 1'b1;
                    end else if (verify_en) begin
                        rd_req_d = 1'b1;
                        state_d  = RD;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            RD: begin
                if (i2c_read_req_ack) begin
                    rd_req_d = 1'b0;
                    if (i2c_error || (i2c_read_data != data_q)) begin
                        do_fail = 1'b1;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            DLY: begin
                if (delay_q == '0) begin
                    do_adv = 1'b1;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A failed entry either retries the same write or gives up and moves on.
        if (do_fail) begin
            if (retry_q < MAX_RETRY_C) begin
                retry_d  = retry_q + 4'd1;
                wr_req_d = 1'b1;
                state_d  = WR;
            end else begin
                error_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                do_adv = 1'b1;
            end
        end

        // The last table slot ends the run instead of wrapping to entry 0.
        if (do_adv) begin
            retry_d = '0;
            if (lut_index_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                lut_index_d = lut_index_q + 1'b1;
                state_d     = CHECK;
            end
        end
    end

    assign lut_index          = lut_index_q;
    assign i2c_write_req      = wr_req_q;
    assign i2c_read_req       = rd_req_q;
    assign i2c_slave_dev_addr = dev_q;
    assign i2c_slave_reg_addr = reg_q;
    assign i2c_write_data     = data_q;
    assign busy               = (state_q != IDLE) && (state_q != DONE);
    assign done               = (state_q == DONE);
    assign error              = error_q;
    assign err_cnt            = err_cnt_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Self-checking bench for i2c_config_seq: directed scenarios plus randomized
// tables and I2C responses compared against an entry-level reference model.
module tb_i2c_config_seq;

    localparam int AW        = 2;
    localparam int NENT      = 4;
    localparam int MAXR      = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          verify_en;
    logic [AW-1:0] lut_index;
    logic [7:0]    lut_dev_addr;
    logic [15:0]   lut_reg_addr;
    logic [7:0]    lut_reg_data;
    logic          i2c_write_req;
    logic          i2c_read_req;
    logic          wr_ack;
    logic          rd_ack;
    logic          i2c_error;
    logic [7:0]    i2c_read_data;
    logic [7:0]    i2c_slave_dev_addr;
    logic [15:0]   i2c_slave_reg_addr;
    logic [7:0]    i2c_write_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    err_cnt;

    logic [7:0]    dev_mem  [NENT];
    logic [15:0]   reg_mem  [NENT];
    logic [7:0]    data_mem [NENT];

    int total = 0;
    int bad   = 0;

    // Responder bookkeeping; read plan codes: 0 good, 1 wrong data, 2 NACK.
    bit resp_wr [$];
    int resp_rd [$];
    bit wr_plan [$];
    int rd_plan [$];
    int wr_count, rd_count, busy_cycles, lat;
    bit both_seen, req_seen, resp_en, pend;

    int          exp_idx, exp_wr, exp_rd, exp_errc;
    bit          exp_err;
    logic [7:0]  exp_dev, exp_data;
    logic [15:0] exp_reg;

    i2c_config_seq #(.LUT_AW(AW), .MAX_RETRY(MAXR), .DELAY_W(24)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .verify_en          (verify_en),
        .lut_index          (lut_index),
        .lut_dev_addr       (lut_dev_addr),
        .lut_reg_addr       (lut_reg_addr),
        .lut_reg_data       (lut_reg_data),
        .i2c_write_req      (i2c_write_req),
        .i2c_read_req       (i2c_read_req),
        .i2c_write_req_ack  (wr_ack),
        .i2c_read_req_ack   (rd_ack),
        .i2c_error          (i2c_error),
        .i2c_read_data      (i2c_read_data),
        .i2c_slave_dev_addr (i2c_slave_dev_addr),
        .i2c_slave_reg_addr (i2c_slave_reg_addr),
        .i2c_write_data     (i2c_write_data),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .err_cnt            (err_cnt)
    );

    assign lut_dev_addr = dev_mem[lut_index];
    assign lut_reg_addr = reg_mem[lut_index];
    assign lut_reg_data = data_mem[lut_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C master stand-in: acks each request after a random latency.
    initial begin
        wr_ack = 1'b0; rd_ack = 1'b0; i2c_error = 1'b0; i2c_read_data = 8'h00;
        pend = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0; rd_ack = 1'b0; i2c_error = 1'b0;
            if (i2c_write_req && i2c_read_req) both_seen = 1'b1;
            if (i2c_write_req || i2c_read_req) req_seen = 1'b1;
            if (!resp_en || !(i2c_write_req || i2c_read_req)) begin
                pend = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    lat  = int'($urandom_range(0, 3));
                end
                if (lat == 0) begin
                    pend = 1'b0;
                    if (i2c_write_req) begin
                        wr_count++;
                        i2c_error = (resp_wr.size() > 0) ? resp_wr.pop_front() : 1'b0;
                        wr_ack = 1'b1;
                    end else begin
                        int code;
                        rd_count++;
                        code = (resp_rd.size() > 0) ? resp_rd.pop_front() : 0;
                        i2c_read_data = i2c_write_data;
                        if (code == 1) i2c_read_data = (i2c_write_data != 8'h00) ? 8'h00 : 8'hFF;
                        i2c_error = (code == 2);
                        rd_ack = 1'b1;
                    end
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setEntry(input int i, input logic [7:0] d, input logic [15:0] r, input logic [7:0] v);
        dev_mem[i] = d; reg_mem[i] = r; data_mem[i] = v;
    endtask

    // Entry-level reference: each write entry gets up to MAXR+1 attempts.
    task automatic modelRun(input bit verify);
        int  idx, wi, ri, att;
        bit  fin, ok, we;
        idx = 0; wi = 0; ri = 0; fin = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_err = 1'b0; exp_errc = 0;
        while (!fin) begin
            if (dev_mem[idx] == 8'hFF) begin
                fin = 1'b1;
            end else begin
                if (dev_mem[idx] != 8'hFE) begin
                    ok = 1'b0; att = 0;
                    while (!ok && att <= MAXR) begin
                        exp_wr++;
                        we = (wi < wr_plan.size()) ? wr_plan[wi] : 1'b0;
                        wi++;
                        exp_dev = dev_mem[idx]; exp_reg = reg_mem[idx]; exp_data = data_mem[idx];
                        if (!we) begin
                            if (!verify) begin
                                ok = 1'b1;
                            end else begin
                                exp_rd++;
                                ok = ((ri < rd_plan.size()) ? rd_plan[ri] : 0) == 0;
                                ri++;
                            end
                        end
                        att++;
                    end
                    if (!ok) begin
                        exp_err = 1'b1;
                        exp_errc++;
                    end
                end
                if (idx == NENT - 1) fin = 1'b1;
                else idx++;
            end
        end
        exp_idx = idx;
    endtask

    task automatic applyStimulus(input bit verify, input string name);
        modelRun(verify);
        resp_wr = wr_plan;
        resp_rd = rd_plan;
        wr_count = 0; rd_count = 0; both_seen = 1'b0; req_seen = 1'b0;
        verify_en = verify;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cycles = int'(busy);
        for (int c = 0; c < 3000; c++) begin
            if (done) break;
            @(negedge clk);
            busy_cycles += int'(busy);
        end
        checkOutput({name, "_done"},    32'(done),               32'd1);
        checkOutput({name, "_busy"},    32'(busy),               32'd0);
        checkOutput({name, "_idx"},     32'(lut_index),          32'(exp_idx));
        checkOutput({name, "_writes"},  32'(wr_count),           32'(exp_wr));
        checkOutput({name, "_reads"},   32'(rd_count),           32'(exp_rd));
        checkOutput({name, "_error"},   32'(error),              32'(exp_err));
        checkOutput({name, "_err_cnt"}, 32'(err_cnt),            32'(exp_errc));
        checkOutput({name, "_overlap"}, 32'(both_seen),          32'd0);
        checkOutput({name, "_dev"},     32'(i2c_slave_dev_addr), 32'(exp_dev));
        checkOutput({name, "_reg"},     32'(i2c_slave_reg_addr), 32'(exp_reg));
        checkOutput({name, "_wdata"},   32'(i2c_write_data),     32'(exp_data));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; verify_en = 1'b0; resp_en = 1'b1;
        both_seen = 1'b0; req_seen = 1'b0; wr_count = 0; rd_count = 0;
        exp_dev = 8'h00; exp_reg = 16'h0000; exp_data = 8'h00;
        for (int i = 0; i < NENT; i++) setEntry(i, 8'hFF, 16'h0000, 8'h00);
        #12;
        checkOutput("reset_busy",   32'(busy),          32'd0);
        checkOutput("reset_done",   32'(done),          32'd0);
        checkOutput("reset_wreq",   32'(i2c_write_req), 32'd0);
        checkOutput("reset_idx",    32'(lut_index),     32'd0);
        checkOutput("reset_errcnt", 32'(err_cnt),       32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] two plain writes then end marker");
        setEntry(0, 8'h20, 16'h0010, 8'h11);
        setEntry(1, 8'h21, 16'h0020, 8'h22);
        setEntry(2, 8'hFF, 16'h0000, 8'h00);
        wr_plan = {}; rd_plan = {};
        applyStimulus(1'b0, "plain");
        checkOutput("plain_writes_const", 32'(wr_count),  32'd2);
        checkOutput("plain_idx_const",    32'(lut_index), 32'd2);

        $display("[TB] verified write, good read-back");
        setEntry(0, 8'h30, 16'h0100, 8'h5A);
        setEntry(1, 8'hFF, 16'h0000, 8'h00);
        applyStimulus(1'b1, "verify_ok");
        checkOutput("verify_ok_reads_const", 32'(rd_count), 32'd1);

        $display("[TB] verified write, read-back always wrong");
        setEntry(0, 8'h30, 16'h0100, 8'h5A);
        setEntry(1, 8'h31, 16'h0200, 8'h33);
        setEntry(2, 8'hFF, 16'h0000, 8'h00);
        rd_plan = {1, 1, 1, 1};
        applyStimulus(1'b1, "verify_bad");
        checkOutput("verify_bad_writes_const", 32'(wr_count), 32'd5);
        checkOutput("verify_bad_errcnt_const", 32'(err_cnt),  32'd1);

        $display("[TB] delay entry of 5");
        setEntry(0, 8'hFE, 16'h0000, 8'h05);
        setEntry(1, 8'hFF, 16'h0000, 8'h00);
        wr_plan = {}; rd_plan = {};
        applyStimulus(1'b0, "delay");
        checkOutput("delay_busy_cycles", 32'(busy_cycles), 32'd8);
        checkOutput("delay_no_requests", 32'(req_seen),    32'd0);

        $display("[TB] NACK on first write attempt only");
        setEntry(0, 8'h44, 16'h0A0B, 8'h99);
        setEntry(1, 8'hFF, 16'h0000, 8'h00);
        wr_plan = {1'b1, 1'b0};
        applyStimulus(1'b0, "nack_once");
        checkOutput("nack_once_writes_const", 32'(wr_count), 32'd2);
        checkOutput("nack_once_error_const",  32'(error),    32'd0);

        $display("[TB] reset during an outstanding write");
        setEntry(0, 8'h42, 16'h1234, 8'h77);
        wr_plan = {};
        resp_en = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (i2c_write_req) break;
            @(negedge clk);
        end
        checkOutput("rst_req_before", 32'(i2c_write_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_wreq",  32'(i2c_write_req),      32'd0);
        checkOutput("rst_rreq",  32'(i2c_read_req),       32'd0);
        checkOutput("rst_busy",  32'(busy),               32'd0);
        checkOutput("rst_idx",   32'(lut_index),          32'd0);
        checkOutput("rst_dev",   32'(i2c_slave_dev_addr), 32'd0);
        checkOutput("rst_reg",   32'(i2c_slave_reg_addr), 32'd0);
        checkOutput("rst_wdata", 32'(i2c_write_data),     32'd0);
        exp_dev = 8'h00; exp_reg = 16'h0000; exp_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; resp_en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_idle_busy", 32'(busy),          32'd0);
        checkOutput("post_rst_idle_done", 32'(done),          32'd0);
        checkOutput("post_rst_idle_wreq", 32'(i2c_write_req), 32'd0);
        applyStimulus(1'b0, "post_rst");

        $display("[TB] full table, no end marker");
        for (int i = 0; i < NENT; i++) setEntry(i, 8'h50 + 8'(i), 16'h0300 + 16'(i), 8'hC0 + 8'(i));
        wr_plan = {}; rd_plan = {};
        applyStimulus(1'b0, "no_ff");
        checkOutput("no_ff_idx_const",    32'(lut_index), 32'd3);
        checkOutput("no_ff_writes_const", 32'(wr_count),  32'd4);

        $display("[TB] randomized tables");
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NENT; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      setEntry(i, 8'hFF, 16'h0000, 8'h00);
                else if (r <= 2) setEntry(i, 8'hFE, 16'h0000, 8'($urandom_range(0, 6)));
                else             setEntry(i, 8'($urandom_range(0, 8'hFD)), 16'($urandom), 8'($urandom));
            end
            wr_plan = {}; rd_plan = {};
            for (int k = 0; k < 12; k++) begin
                wr_plan.push_back($urandom_range(0, 3) == 0);
                rd_plan.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            applyStimulus(1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
